// File: rtl/delta_dec_pkg.sv
// Shared types and default sizing for the delta accumulator decoder.
package delta_dec_pkg;

  localparam int unsigned DefFrameLen = 8;
  localparam int unsigned DefAccW     = 8;
  localparam int unsigned DeltaW      = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/sat_add_signed.sv
// Unsigned base plus small signed delta, clamped to [0, 2^AccW-1] with a saturation flag.
module sat_add_signed
  import delta_dec_pkg::*;
#(
  parameter int unsigned AccW = DefAccW
) (
  input  logic [AccW-1:0]   base_i,
  input  logic [DeltaW-1:0] delta_i,
  output logic [AccW-1:0]   sum_o,
  output logic              sat_o
);

  // Two guard bits: top bit flags a negative sum, next bit flags overflow.
  logic [AccW+1:0] sum;

  always_comb begin
    sum   = {2'b00, base_i} + {{(AccW + 2 - DeltaW){delta_i[DeltaW-1]}}, delta_i};
    sum_o = sum[AccW-1:0];
    sat_o = 1'b0;
    if (sum[AccW+1]) begin
      sum_o = '0;
      sat_o = 1'b1;
    end else if (sum[AccW]) begin
      sum_o = '1;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/delta_accum_decoder.sv
// Frame-based delta decoder: integrates signed deltas from a seed into a clamped running value
// and presents each sample through a single-entry valid/ready output register.
module delta_accum_decoder
  import delta_dec_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned ACC_W     = DefAccW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DeltaW-1:0] in_delta,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_value,
  output logic              out_sat,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_value_q, out_value_d;
  logic             out_sat_q, out_sat_d;
  logic [ACC_W-1:0] sum;
  logic             sat;
  logic             xfer;

  sat_add_signed #(
    .AccW(ACC_W)
  ) u_sat_add (
    .base_i (acc_q),
    .delta_i(in_delta),
    .sum_o  (sum),
    .sat_o  (sat)
  );

  // Accept only when the output register is free or being drained this cycle.
  assign in_ready   = (state_q == StRun) && (!out_valid_q || out_ready);
  assign xfer       = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign out_sat    = out_sat_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          acc_d   = seed;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (xfer) begin
          acc_d = sum;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      out_valid_d = 1'b1;
      out_value_d = sum;
      out_sat_d   = sat;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: doc/delta_accum_decoder.md
DELTA_ACCUM_DECODER -- requirements
Module: delta_accum_decoder

Interface
REQ-001 Parameter: FRAME_LEN, default 8, meaning deltas accepted per frame (legal 1..255).
REQ-002 Parameter: ACC_W, default 8, meaning unsigned width of the reconstructed value.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  single-cycle frame-start request; sampled only in IDLE.
REQ-006 Port: seed  in  ACC_W  initial accumulator value, captured with start.
REQ-007 Port: in_valid  in  1  in_delta is valid this cycle.
REQ-008 Port: in_ready  out  1  block accepts in_delta this cycle.
REQ-009 Port: in_delta  in  5  two's-complement difference, range -16..+15.
REQ-010 Port: out_valid  out  1  out_value/out_sat hold a reconstructed sample.
REQ-011 Port: out_ready  in  1  downstream consumes the sample this cycle.
REQ-012 Port: out_value  out  ACC_W  reconstructed running value.
REQ-013 Port: out_sat  out  1  this sample was clamped.
REQ-014 Port: busy  out  1  high in RUN and DONE.
REQ-015 Port: frame_done  out  1  one-cycle pulse after the last delta of a frame is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start=1: acc<=seed, cnt<=0. start SHALL be ignored in RUN and DONE.
REQ-018 in_ready SHALL be (state==RUN) && (!out_valid || out_ready), and SHALL be 0 in IDLE and DONE.
REQ-019 Transfer SHALL occur on in_valid && in_ready, and then: acc <= clamp(acc + sign_extend(in_delta)), out_value <= that result, out_valid <= 1, cnt <= cnt+1.
REQ-020 Clamp: sums below 0 SHALL become 0, sums above 2^ACC_W-1 SHALL become 2^ACC_W-1, and out_sat SHALL be 1 for that sample only.
REQ-021 Latency: out_valid SHALL rise the cycle after the accepting edge (1 cycle).
REQ-022 out_valid, out_value and out_sat SHALL stay stable while out_valid && !out_ready.
REQ-023 out_valid SHALL clear on out_valid && out_ready with no new transfer in the same cycle.
REQ-024 A simultaneous consume and transfer SHALL reload the output register, keeping out_valid=1 (full throughput, one delta per cycle).
REQ-025 The transfer with cnt==FRAME_LEN-1 SHALL move RUN->DONE.
REQ-026 DONE SHALL last exactly one cycle with frame_done=1 and then go to IDLE.
REQ-027 The final sample MAY still be pending in IDLE and SHALL drain normally via out_ready.
REQ-028 A start in IDLE while out_valid=1 SHALL be accepted, but in_ready SHALL stay 0 until the pending sample is consumed.
REQ-029 in_delta is "don't care" when in_valid=0 and SHALL NOT affect state.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, acc=0, cnt=0, out_valid=0, out_value=0, out_sat=0, frame_done=0, in_ready=0 and busy=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done pulse; after release, operation SHALL resume from IDLE only.

Structure
REQ-032 Shared package delta_dec_pkg SHALL hold the state enum, the default FRAME_LEN and ACC_W constants, and the 5-bit delta width constant.
REQ-033 The clamp SHALL live in one combinational sub-module, sat_add_signed (ACC_W-bit unsigned base plus 5-bit signed delta gives a value and a sat flag).
REQ-034 Everything else SHALL be a single always block set plus continuous assigns in delta_accum_decoder.

Verification
REQ-035 Basic: seed=100, deltas +5,-3,+15,-16, out_ready=1 -> out_value 105,102,117,101, out_sat=0 throughout.
REQ-036 Saturation: seed=250, deltas +15,-16; then seed=3, delta -5 -> outputs 255(sat=1), 239(sat=0); then 0(sat=1).
REQ-037 Backpressure: out_ready=0 for 4 cycles after the first sample -> in_ready=0 and out_value held; on release, consecutive deltas stream at 1 per cycle.
REQ-038 Frame end: FRAME_LEN=8 with 8 deltas -> frame_done pulses once the cycle after the 8th transfer; a 9th in_valid is not accepted; start during RUN is ignored.
REQ-039 Reset mid-frame: rst asserted after 3 of 8 deltas -> all outputs 0 immediately, no frame_done; a new start with seed=7 and delta +1 -> 8.
REQ-040 Random streams versus a reference integrator model with clamping, with random in_valid/out_ready -> all samples match in order and none are lost or duplicated.
